manchester_unescape: RTL and testbench
======================================

# manchester_unescape

Receive-side counterpart of the Manchester byte-stuffing transmitter. It consumes an escaped AXI-Stream payload (start word already stripped by the deframer) and restores the original bytes: ESCAPE,REPLACE becomes START_WORD, and ESCAPE,ESCAPE becomes ESCAPE. It drops malformed sequences, always preserves frame boundaries (tlast), flags damaged frames on the last beat, and counts errors. It sits between the Manchester deframer and the packet consumer.

## Interface
- DATA_WIDTH, 8, byte width of both streams
- START_WORD, 8'hD5, frame start symbol; never legal unescaped in the payload
- ESCAPE_SYMBOL, 8'hE5, escape prefix
- REPLACE_SYMBOL, 8'hF5, escaped stand-in for START_WORD
- ERR_CNT_WIDTH, 16, error counter width

Ports:
- aclk  in  1  single clock
- aresetn  in  1  asynchronous, active-low reset
- s_axis_tdata  in  DATA_WIDTH  escaped input byte
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  last input byte of frame
- m_axis_tdata  out  DATA_WIDTH  decoded byte
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  last decoded byte of frame
- m_axis_tuser  out  1  frame-error flag, meaningful only when tlast=1
- err_count  out  ERR_CNT_WIDTH  saturating count of decode errors
- err_pulse  out  1  one-cycle pulse per decode error

## Operation
- Decoder FSM has two states, REGULAR and ESCAPE. Transitions advance only on an input handshake (s_tvalid & s_tready).
- REGULAR:
  - byte == ESCAPE_SYMBOL and !tlast: consume it, go to ESCAPE.
  - byte == ESCAPE_SYMBOL and tlast: truncated escape. Drop the byte, record an error, stay in REGULAR.
  - byte == START_WORD: illegal raw start word. Drop the byte, record an error.
  - any other byte: decoded beat carrying the same value.
- ESCAPE:
  - REPLACE_SYMBOL produces decoded START_WORD.
  - ESCAPE_SYMBOL produces decoded ESCAPE_SYMBOL.
  - any other byte: drop both the escape and the byte, record an error.
  - Every case returns to REGULAR.
- Holdback register (pend: data, last, user, valid) makes frame closure possible when the tlast-bearing input is dropped:
  - A decoded beat enters pend. Any prior pend content moves to the output register at the same edge.
  - A dropped beat carrying tlast sets pend.last. If pend is empty, the frame vanishes and nothing is emitted.
  - pend with last=1 moves to the output register as soon as that register is free or draining. It does not wait for new input.
- Frame error flag:
  - Sticky frame_err is set by any error in the current frame.
  - It is copied into pend.user when pend.last is set, then cleared at frame end.
- err_count increments by 1 per error and saturates at all-ones. err_pulse is high the cycle after the error-causing handshake.
- s_axis_tready = !pend.valid || !m_axis_tvalid || m_axis_tready. This is combinational from m_axis_tready and is documented for integrators. A pend with last=1 accepts new input only when it moves in the same cycle.

## Timing
- Reset (asynchronous): m_axis_tvalid/tdata/tlast/tuser = 0, err_count = 0, err_pulse = 0, pend.valid = 0, frame_err = 0, state = REGULAR. s_axis_tready = 1 after reset.
- Latency:
  - Non-last decoded byte: reaches m_axis one edge after the next decoded byte is accepted.
  - Last byte: m_axis_tvalid rises 2 edges after acceptance, with output free.
- Throughput: 1 input byte/cycle while m_axis_tready = 1. An escape pair yields 1 output per 2 inputs.
- AXI rules: m_axis_tvalid and its payload hold until handshake. No bubbles are inserted inside a frame when both sides stream.
- Simultaneous m handshake and pend transfer in the same cycle is legal and lossless.
- Reset mid-frame: partial frame discarded, outputs return to reset values immediately. No tlast is generated for the aborted frame.

## Structure
- Shared package manchester_pkg holds:
  - START_WORD/ESCAPE_SYMBOL/REPLACE_SYMBOL defaults and the REGULAR/ESCAPE encodings, used by both the escape transmitter and this block;
  - the error-counter width default.
- Single module; no sub-module. The pend stage and the output register are written inline.

## Test plan
- 11 E5 F5 22(last) -> 11 D5 22(last), tuser=0, err_count=0.
- E5 E5 33 E5 F5(last) with m_axis_tready toggling 1,0,1,0 -> E5 33 D5(last). No loss or duplication, tvalid stable while stalled.
- 33 E5 7A 44(last) -> 33 44(last), tuser=1, err_count=1, one err_pulse.
- 55 E5(last) -> 55(last), tuser=1, err_count=1. The next frame 66(last) -> 66(last) with tuser=0.
- D5(last) alone -> nothing emitted, err_count=1. The next frame is unaffected.
- Assert aresetn low mid-frame after 11 22 -> all outputs zero at once. After release, 77(last) -> 77(last), err_count=0.

Source files
------------

// File: rtl/manchester_pkg.sv
// ---------------------------------------------------------------------------
// manchester_pkg
// Shared constants for the Manchester byte-stuffing transmitter and the
// receive-side unescaper.
//   DEFAULT_START_WORD     frame start symbol, never legal raw in a payload
//   DEFAULT_ESCAPE_SYMBOL  escape prefix
//   DEFAULT_REPLACE_SYMBOL escaped stand-in for the start word
//   DEFAULT_ERR_CNT_WIDTH  default width of the decode error counter
//   STATE_REGULAR/ESCAPE   decoder state encodings shared by both blocks
// ---------------------------------------------------------------------------
package manchester_pkg;

    localparam logic [7:0] DEFAULT_START_WORD     = 8'hD5;
    localparam logic [7:0] DEFAULT_ESCAPE_SYMBOL  = 8'hE5;
    localparam logic [7:0] DEFAULT_REPLACE_SYMBOL = 8'hF5;

    localparam int DEFAULT_ERR_CNT_WIDTH = 16;

    localparam logic [0:0] STATE_REGULAR = 1'b0;
    localparam logic [0:0] STATE_ESCAPE  = 1'b1;

endpackage

// File: rtl/manchester_unescape.sv
// ---------------------------------------------------------------------------
// manchester_unescape
// Restores the original payload bytes from an escaped AXI-Stream payload
// whose start word has already been stripped by the deframer.
//   ESCAPE,REPLACE -> START_WORD ; ESCAPE,ESCAPE -> ESCAPE
// Malformed sequences are dropped, frame boundaries (tlast) are always kept,
// damaged frames are flagged on tuser of their last beat, and errors are
// counted.
// Ports:
//   aclk, aresetn      clock, asynchronous active-low reset
//   s_axis_*           escaped input stream (tdata/tvalid/tready/tlast)
//   m_axis_*           decoded output stream (tdata/tvalid/tready/tlast)
//   m_axis_tuser       frame-error flag, meaningful only with tlast
//   err_count          saturating count of decode errors
//   err_pulse          one-cycle pulse per decode error
// Note: s_axis_tready is combinational from m_axis_tready.
// ---------------------------------------------------------------------------
module manchester_unescape
    import manchester_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 8,
    parameter logic [DATA_WIDTH-1:0] START_WORD     = DEFAULT_START_WORD,
    parameter logic [DATA_WIDTH-1:0] ESCAPE_SYMBOL  = DEFAULT_ESCAPE_SYMBOL,
    parameter logic [DATA_WIDTH-1:0] REPLACE_SYMBOL = DEFAULT_REPLACE_SYMBOL,
    parameter int                    ERR_CNT_WIDTH  = DEFAULT_ERR_CNT_WIDTH
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     s_axis_tlast,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tuser,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic                     err_pulse
);

    localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE = 1;

    // Decoder state
    logic [0:0] state_q, state_d;

    // Holdback stage
    logic [DATA_WIDTH-1:0] pendData_q, pendData_d;
    logic                  pendValid_q, pendValid_d;
    logic                  pendLast_q, pendLast_d;
    logic                  pendUser_q, pendUser_d;

    // Output register
    logic [DATA_WIDTH-1:0] outData_q, outData_d;
    logic                  outValid_q, outValid_d;
    logic                  outLast_q, outLast_d;
    logic                  outUser_q, outUser_d;

    // Error bookkeeping
    logic                     frameErr_q, frameErr_d;
    logic [ERR_CNT_WIDTH-1:0] errCount_q, errCount_d;
    logic                     errPulse_q, errPulse_d;

    logic                  inHs;
    logic                  outFree;
    logic                  pendMove;
    logic                  decValid;
    logic [DATA_WIDTH-1:0] decData;
    logic                  decErr;

    // The output register can take a new beat when empty or draining now.
    assign outFree       = !outValid_q || m_axis_tready;
    assign s_axis_tready = !pendValid_q || outFree;
    assign inHs          = s_axis_tvalid && s_axis_tready;

    // Byte decoder: classifies the accepted byte as decoded, consumed escape
    // prefix or error, and picks the next state.
    always_comb begin
        decValid = 1'b0;
        decData  = s_axis_tdata;
        decErr   = 1'b0;
        state_d  = state_q;
        if (inHs) begin
            if (state_q == STATE_REGULAR) begin
                if (s_axis_tdata == ESCAPE_SYMBOL) begin
                    // An escape cannot be completed past the frame end.
                    if (s_axis_tlast) begin
                        decErr = 1'b1;
                    end else begin
                        state_d = STATE_ESCAPE;
                    end
                end else if (s_axis_tdata == START_WORD) begin
                    decErr = 1'b1;
                end else begin
                    decValid = 1'b1;
                end
            end else begin
                state_d = STATE_REGULAR;
                if (s_axis_tdata == REPLACE_SYMBOL) begin
                    decValid = 1'b1;
                    decData  = START_WORD;
                end else if (s_axis_tdata == ESCAPE_SYMBOL) begin
                    decValid = 1'b1;
                end else begin
                    decErr = 1'b1;
                end
            end
        end
    end

    // Pend leaves for the output register when a newer decoded beat pushes
    // it out, or on its own once it closes a frame; the output must be free.
    // s_axis_tready guarantees outFree whenever a beat pushes a valid pend.
    assign pendMove = pendValid_q && outFree && (pendLast_q || decValid);

    // Holdback stage: lets a dropped tlast-bearing byte still close the frame
    // by marking the beat already waiting here as last.
    always_comb begin
        pendData_d  = pendData_q;
        pendValid_d = pendValid_q;
        pendLast_d  = pendLast_q;
        pendUser_d  = pendUser_q;
        if (pendMove) begin
            pendValid_d = 1'b0;
            pendLast_d  = 1'b0;
            pendUser_d  = 1'b0;
        end
        if (decValid) begin
            pendData_d  = decData;
            pendValid_d = 1'b1;
            pendLast_d  = s_axis_tlast;
            pendUser_d  = s_axis_tlast && frameErr_q;
        end else if (inHs && s_axis_tlast && pendValid_d) begin
            pendLast_d = 1'b1;
            pendUser_d = frameErr_q || decErr;
        end
    end

    // Output register: loads from pend, otherwise empties after a handshake.
    always_comb begin
        outData_d  = outData_q;
        outValid_d = outValid_q;
        outLast_d  = outLast_q;
        outUser_d  = outUser_q;
        if (pendMove) begin
            outData_d  = pendData_q;
            outValid_d = 1'b1;
            outLast_d  = pendLast_q;
            outUser_d  = pendUser_q;
        end else if (outFree) begin
            outValid_d = 1'b0;
        end
    end

    // Sticky per-frame error flag, saturating counter and error pulse.
    always_comb begin
        frameErr_d = frameErr_q;
        errCount_d = errCount_q;
        errPulse_d = inHs && decErr;
        if (inHs) begin
            frameErr_d = s_axis_tlast ? 1'b0 : (frameErr_q || decErr);
        end
        if (inHs && decErr && (errCount_q != {ERR_CNT_WIDTH{1'b1}})) begin
            errCount_d = errCount_q + ERR_ONE;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= STATE_REGULAR;
            pendData_q  <= '0;
            pendValid_q <= 1'b0;
            pendLast_q  <= 1'b0;
            pendUser_q  <= 1'b0;
            outData_q   <= '0;
            outValid_q  <= 1'b0;
            outLast_q   <= 1'b0;
            outUser_q   <= 1'b0;
            frameErr_q  <= 1'b0;
            errCount_q  <= '0;
            errPulse_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pendData_q  <= pendData_d;
            pendValid_q <= pendValid_d;
            pendLast_q  <= pendLast_d;
            pendUser_q  <= pendUser_d;
            outData_q   <= outData_d;
            outValid_q  <= outValid_d;
            outLast_q   <= outLast_d;
            outUser_q   <= outUser_d;
            frameErr_q  <= frameErr_d;
            errCount_q  <= errCount_d;
            errPulse_q  <= errPulse_d;
        end
    end

    assign m_axis_tdata  = outData_q;
    assign m_axis_tvalid = outValid_q;
    assign m_axis_tlast  = outLast_q;
    assign m_axis_tuser  = outUser_q;
    assign err_count     = errCount_q;
    assign err_pulse     = errPulse_q;

endmodule

// File: tb/tb_manchester_unescape.sv
// ---------------------------------------------------------------------------
// tb_manchester_unescape
// Directed frames through manchester_unescape with hand-computed decoded
// beats, frame-error flags and error counts. Output beats are recorded as
// {tlast, tuser, tdata}; tuser is only compared on last beats.
// ---------------------------------------------------------------------------
module tb_manchester_unescape;

    logic        aclk;
    logic        aresetn;
    logic [7:0]  sTdata;
    logic        sTvalid;
    logic        sTready;
    logic        sTlast;
    logic [7:0]  mTdata;
    logic        mTvalid;
    logic        mTready;
    logic        mTlast;
    logic        mTuser;
    logic [15:0] errCount;
    logic        errPulse;

    int checks;
    int errors;
    int pulseCount;

    logic [8:0] stimQ[$];
    logic [9:0] outQ[$];
    logic [9:0] expQ[$];

    manchester_unescape dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (sTdata),
        .s_axis_tvalid (sTvalid),
        .s_axis_tready (sTready),
        .s_axis_tlast  (sTlast),
        .m_axis_tdata  (mTdata),
        .m_axis_tvalid (mTvalid),
        .m_axis_tready (mTready),
        .m_axis_tlast  (mTlast),
        .m_axis_tuser  (mTuser),
        .err_count     (errCount),
        .err_pulse     (errPulse)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Streams stimQ into the DUT, optionally toggling m_axis_tready
    // 1,0,1,0..., and records every output handshake into outQ. Inputs change
    // just after the rising edge; everything is observed on the falling edge.
    task automatic applyStimulus(input bit toggleReady);
        int         idx;
        int         cyc;
        int         drain;
        bit         prevStall;
        logic [10:0] prevOut;
        idx        = 0;
        cyc        = 0;
        drain      = 8;
        prevStall  = 1'b0;
        prevOut    = '0;
        pulseCount = 0;
        outQ.delete();
        while ((idx < stimQ.size() || drain > 0) && cyc < 300) begin
            if (idx < stimQ.size()) begin
                sTvalid = 1'b1;
                sTlast  = stimQ[idx][8];
                sTdata  = stimQ[idx][7:0];
            end else begin
                sTvalid = 1'b0;
                sTlast  = 1'b0;
                sTdata  = 8'h00;
            end
            mTready = toggleReady ? ((cyc % 2) == 0) : 1'b1;
            @(negedge aclk);
            if (prevStall) begin
                checkOutput("stall_hold", {21'd0, mTvalid, mTlast, mTdata}, {21'd0, prevOut});
            end
            prevStall = mTvalid && !mTready;
            prevOut   = {mTvalid, mTlast, mTdata};
            if (mTvalid && mTready) outQ.push_back({mTlast, mTuser, mTdata});
            if (errPulse) pulseCount++;
            if (sTvalid && sTready) idx++;
            else if (idx >= stimQ.size()) drain--;
            @(posedge aclk);
            #1;
            cyc++;
        end
        sTvalid = 1'b0;
        sTlast  = 1'b0;
        mTready = 1'b1;
        if (idx < stimQ.size()) begin
            checkOutput("input_timeout", idx, stimQ.size());
        end
    endtask

    // Compares the recorded beats with expQ, then the error counter and pulses.
    task automatic checkFrame(input string tag, input int expErrCount, input int expPulses);
        logic [9:0] obs;
        int         n;
        checkOutput({tag, "_len"}, outQ.size(), expQ.size());
        n = (outQ.size() < expQ.size()) ? outQ.size() : expQ.size();
        for (int i = 0; i < n; i++) begin
            obs = outQ[i];
            if (!expQ[i][9]) obs[8] = 1'b0;
            checkOutput($sformatf("%s_beat%0d", tag, i), {22'd0, obs}, {22'd0, expQ[i]});
        end
        checkOutput({tag, "_errcount"}, {16'd0, errCount}, expErrCount);
        checkOutput({tag, "_pulses"}, pulseCount, expPulses);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        aresetn = 1'b0;
        sTvalid = 1'b0;
        sTlast  = 1'b0;
        sTdata  = 8'h00;
        mTready = 1'b1;

        #12;
        checkOutput("rst_tvalid", {31'd0, mTvalid}, 0);
        checkOutput("rst_tdata", {24'd0, mTdata}, 0);
        checkOutput("rst_tlast_tuser", {30'd0, mTlast, mTuser}, 0);
        checkOutput("rst_errcount", {16'd0, errCount}, 0);
        checkOutput("rst_errpulse", {31'd0, errPulse}, 0);
        checkOutput("rst_tready", {31'd0, sTready}, 1);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // Escaped start word in the middle of a clean frame.
        stimQ = '{9'h011, 9'h0E5, 9'h0F5, 9'h122};
        expQ  = '{10'h011, 10'h0D5, 10'h222};
        applyStimulus(1'b0);
        checkFrame("f1", 0, 0);

        // Escaped escape and escaped start word under backpressure.
        stimQ = '{9'h0E5, 9'h0E5, 9'h033, 9'h0E5, 9'h1F5};
        expQ  = '{10'h0E5, 10'h033, 10'h2D5};
        applyStimulus(1'b1);
        checkFrame("f2", 0, 0);

        // Invalid escape pair is dropped, frame flagged.
        stimQ = '{9'h033, 9'h0E5, 9'h07A, 9'h144};
        expQ  = '{10'h033, 10'h344};
        applyStimulus(1'b0);
        checkFrame("f3", 1, 1);

        // Truncated escape on the last byte closes the frame on the held beat.
        stimQ = '{9'h055, 9'h1E5};
        expQ  = '{10'h355};
        applyStimulus(1'b0);
        checkFrame("f4", 2, 1);

        stimQ = '{9'h166};
        expQ  = '{10'h266};
        applyStimulus(1'b0);
        checkFrame("f5", 2, 0);

        // A lone raw start word: the whole frame vanishes.
        stimQ = '{9'h1D5};
        expQ.delete();
        applyStimulus(1'b0);
        checkFrame("f6", 3, 1);

        stimQ = '{9'h00A, 9'h10B};
        expQ  = '{10'h00A, 10'h20B};
        applyStimulus(1'b0);
        checkFrame("f7", 3, 0);

        // Mid-frame reset with output stalled and a beat in holdback.
        mTready = 1'b0;
        sTvalid = 1'b1;
        sTlast  = 1'b0;
        sTdata  = 8'h11;
        @(posedge aclk);
        #1;
        sTdata = 8'h22;
        @(posedge aclk);
        #1;
        sTvalid = 1'b0;
        checkOutput("prerst_tvalid", {31'd0, mTvalid}, 1);
        checkOutput("prerst_tdata", {24'd0, mTdata}, 32'h11);
        #2;
        aresetn = 1'b0;
        #1;
        checkOutput("midrst_tvalid", {31'd0, mTvalid}, 0);
        checkOutput("midrst_tdata", {24'd0, mTdata}, 0);
        checkOutput("midrst_errcount", {16'd0, errCount}, 0);
        checkOutput("midrst_tready", {31'd0, sTready}, 1);
        @(negedge aclk);
        aresetn = 1'b1;
        mTready = 1'b1;
        @(posedge aclk);
        #1;

        // The discarded 22 must not resurface ahead of the new frame.
        stimQ = '{9'h177};
        expQ  = '{10'h277};
        applyStimulus(1'b0);
        checkFrame("f8", 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
